// File: rtl/bcd_pkg.sv
// ============================================================================
// bcd_pkg : shared BCD widths, digit limit and controller state encoding.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_fadd_1digit.sv
// ============================================================================
// bcd_fadd_1digit : combinational single-digit BCD full adder.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_fadd_1digit
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    input  logic               c_i,
    output logic [DIGIT_W-1:0] s_o,
    output logic               c_o
);

    logic [DIGIT_W:0] raw;

    always_comb begin
        raw = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT_W{1'b0}}, c_i};
        if (raw > {1'b0, BCD_MAX}) begin
            // Skip the six unused codes A..F to wrap back into decimal.
            s_o = DIGIT_W'(raw + (DIGIT_W+1)'(6));
            c_o = 1'b1;
        end else begin
            s_o = raw[DIGIT_W-1:0];
            c_o = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
// ============================================================================
// bcd_serial_add_ctrl : digit-serial BCD adder, one shared digit adder, LSD first.
// Optional macro BCD_SERIAL_DIGIT_CHECK_EN adds err output for non-BCD operands.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*DIGITS-1:0]     a,
    input  logic [4*DIGITS-1:0]     b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     sum,
`ifdef BCD_SERIAL_DIGIT_CHECK_EN
    output logic                    err,
`endif
    output logic                    cout
);

    localparam int SUM_W = DIGIT_W * DIGITS;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   a_q, a_d;
    logic [SUM_W-1:0]   b_q, b_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               err_q, err_d;

    logic [DIGIT_W-1:0] dig_a, dig_b, dig_s;
    logic               dig_c;

    function automatic logic any_invalid(input logic [SUM_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*DIGIT_W +: DIGIT_W] > BCD_MAX) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign dig_a = a_q[idx_q*DIGIT_W +: DIGIT_W];
    assign dig_b = b_q[idx_q*DIGIT_W +: DIGIT_W];

    bcd_fadd_1digit u_fadd (
        .a_i (dig_a),
        .b_i (dig_b),
        .c_i (carry_q),
        .s_o (dig_s),
        .c_o (dig_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
`ifdef BCD_SERIAL_DIGIT_CHECK_EN
                    err_d   = any_invalid(a) | any_invalid(b);
`else
                    err_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*DIGIT_W +: DIGIT_W] = dig_s;
                carry_d = dig_c;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = dig_c;
                    state_d = DONE;
                    // A rejected operand still takes full latency but never reports a value.
                    if (err_q) begin
                        sum_d  = '0;
                        cout_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef BCD_SERIAL_DIGIT_CHECK_EN
    assign err  = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
// ============================================================================
// tb_bcd_serial_add_ctrl : self-checking bench, decimal reference model.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b, sum;
    logic         cin, busy, done, cout;
`ifdef BCD_SERIAL_DIGIT_CHECK_EN
    logic         err;
`endif

    int checks   = 0;
    int failures = 0;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef BCD_SERIAL_DIGIT_CHECK_EN
        .err   (err),
`endif
        .cout  (cout)
    );

    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Decimal reference: plain integer addition, result split into DIGITS digits plus carry.
    task automatic model_add(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                             output logic [W-1:0] es, output logic ec);
        int lim = 1;
        int total;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        total = bcd2int(ma) + bcd2int(mb) + int'(mc);
        es = int2bcd(total % lim);
        ec = (total >= lim);
    endtask

    // Launch one add; lat = edges from accepting edge to done, bcnt = cycles busy was seen.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                          output logic [W-1:0] s, output logic c,
                          output int lat, output int bcnt, output bit to);
        @(negedge clk);
        for (int i = 0; i < 20 && (busy || done); i++) @(negedge clk);
        a = ta; b = tbv; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        lat = 0; bcnt = 0; to = 1'b1;
        for (int n = 1; n <= 3 * DIGITS; n++) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat = n;
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        s = sum; c = cout;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, cout} !== 3'b000 || sum !== '0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b done=%b cout=%b sum=%h required all 0", busy, done, cout, sum);
        end
`ifdef BCD_SERIAL_DIGIT_CHECK_EN
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err err=%b required 0", err);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [3] = '{16'h1234, 16'h9999, 16'h0000};
        logic [W-1:0] vb [3] = '{16'h5678, 16'h0001, 16'h0000};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] xs [3] = '{16'h6912, 16'h0000, 16'h0001};
        logic         xc [3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] s;
        logic c;
        int lat, bcnt;
        bit to;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], s, c, lat, bcnt, to);
            checks++;
            if (to || s !== xs[i] || c !== xc[i]) begin
                failures++;
                $display("FAIL directed_%0d sum=%h cout=%b timeout=%0d required sum=%h cout=%b", i, s, c, to, xs[i], xc[i]);
            end
            // done appears DIGITS edges after the accepting edge (DIGITS+1 counting that edge).
            checks++;
            if (lat != DIGITS || bcnt != DIGITS) begin
                failures++;
                $display("FAIL directed_timing_%0d latency=%0d busy_cycles=%0d required %0d/%0d", i, lat, bcnt, DIGITS, DIGITS);
            end
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || sum !== xs[i] || cout !== xc[i]) begin
                failures++;
                $display("FAIL idle_hold_%0d done=%b busy=%b sum=%h cout=%b required 0 0 %h %b", i, done, busy, sum, cout, xs[i], xc[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] es;
        logic ec;
        int lat = 0;
        bit seen_busy = 1'b0;
        bit to = 1'b1;
        model_add(16'h0123, 16'h0456, 1'b1, es, ec);
        @(negedge clk);
        a = 16'h0123; b = 16'h0456; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 3 * DIGITS; i++) begin
            if (i == 3) begin
                start = 1'b1; a = 16'h9876; b = 16'h9999; cin = 1'b1;
            end
            if (i == 4) start = 1'b0;
            @(posedge clk); #1;
            lat = i;
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to || sum !== es || cout !== ec || lat != DIGITS) begin
            failures++;
            $display("FAIL ignore_start sum=%h cout=%b latency=%0d required sum=%h cout=%b latency=%0d", sum, cout, lat, es, ec, DIGITS);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy) seen_busy = 1'b1;
        end
        checks++;
        if (seen_busy) begin
            failures++;
            $display("FAIL ignore_start_not_queued busy=1 required 0");
        end
    endtask

    task automatic test_midrun_reset();
        logic [W-1:0] s;
        logic c;
        int lat, bcnt;
        bit to;
        run_op(16'h9999, 16'h0001, 1'b0, s, c, lat, bcnt, to);
        @(negedge clk);
        for (int i = 0; i < 20 && (busy || done); i++) @(negedge clk);
        a = 16'h5555; b = 16'h5555; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cout} !== 3'b000 || sum !== '0) begin
            failures++;
            $display("FAIL midrun_reset busy=%b done=%b cout=%b sum=%h required all 0", busy, done, cout, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0005, 16'h0005, 1'b0, s, c, lat, bcnt, to);
        checks++;
        if (to || s !== 16'h0010 || c !== 1'b0 || lat != DIGITS) begin
            failures++;
            $display("FAIL after_reset_add sum=%h cout=%b latency=%0d required sum=0010 cout=0 latency=%0d", s, c, lat, DIGITS);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa [3], ob [3], es [3];
        logic         oc [3], ec [3];
        int k = 0;
        int cyc = 0;
        int last = 0;
        for (int i = 0; i < 3; i++) begin
            oa[i] = rand_bcd(); ob[i] = rand_bcd(); oc[i] = 1'($urandom);
            model_add(oa[i], ob[i], oc[i], es[i], ec[i]);
        end
        @(negedge clk);
        for (int i = 0; i < 20 && (busy || done); i++) @(negedge clk);
        a = oa[0]; b = ob[0]; cin = oc[0]; start = 1'b1;
        for (int n = 0; n < 80 && k < 3; n++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                checks++;
                if (sum !== es[k] || cout !== ec[k]) begin
                    failures++;
                    $display("FAIL b2b_result_%0d sum=%h cout=%b required sum=%h cout=%b", k, sum, cout, es[k], ec[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (cyc - last != DIGITS + 2) begin
                        failures++;
                        $display("FAIL b2b_spacing_%0d spacing=%0d required %0d", k, cyc - last, DIGITS + 2);
                    end
                end
                last = cyc;
                k++;
                if (k < 3) begin
                    a = oa[k]; b = ob[k]; cin = oc[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (k != 3) begin
            failures++;
            $display("FAIL b2b_count done_pulses=%0d required 3", k);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, s, es;
        logic rc, c, ec;
        int lat, bcnt;
        bit to;
        for (int i = 0; i < 16; i++) begin
            ra = rand_bcd(); rb = rand_bcd(); rc = 1'($urandom);
            if (i == 0) begin
                ra = 16'h9999; rb = 16'h9999; rc = 1'b1;
            end
            model_add(ra, rb, rc, es, ec);
            run_op(ra, rb, rc, s, c, lat, bcnt, to);
            checks++;
            if (to || s !== es || c !== ec || lat != DIGITS || bcnt != DIGITS) begin
                failures++;
                $display("FAIL random_%0d %h+%h+%b sum=%h cout=%b lat=%0d busy=%0d required sum=%h cout=%b lat=%0d busy=%0d",
                         i, ra, rb, rc, s, c, lat, bcnt, es, ec, DIGITS, DIGITS);
            end
        end
    endtask

`ifdef BCD_SERIAL_DIGIT_CHECK_EN
    task automatic test_err();
        logic [W-1:0] s;
        logic c;
        int lat, bcnt;
        bit to;
        run_op(16'h00A0, 16'h0001, 1'b0, s, c, lat, bcnt, to);
        checks++;
        if (to || err !== 1'b1 || s !== '0 || c !== 1'b0 || lat != DIGITS) begin
            failures++;
            $display("FAIL err_set err=%b sum=%h cout=%b lat=%0d required err=1 sum=0000 cout=0 lat=%0d", err, s, c, lat, DIGITS);
        end
        run_op(16'h0001, 16'h0002, 1'b0, s, c, lat, bcnt, to);
        checks++;
        if (to || err !== 1'b0 || s !== 16'h0003 || c !== 1'b0) begin
            failures++;
            $display("FAIL err_clear err=%b sum=%h cout=%b required err=0 sum=0003 cout=0", err, s, c);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_midrun_reset();
        test_back_to_back();
        test_random();
`ifdef BCD_SERIAL_DIGIT_CHECK_EN
        test_err();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
